// File: rtl/alu_request_scheduler_if.sv
// Request, datapath and response signals between the ALU scheduler and its environment.
// master = requesters/datapath/consumer side, slave = scheduler side.
interface alu_request_scheduler_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [3:0]       req_op0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [3:0]       req_op1;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_id;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  req_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_n, alu_z, alu_c, alu_v,
        input  rsp_valid, rsp_result, rsp_flags, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output req_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_n, alu_z, alu_c, alu_v,
        output rsp_valid, rsp_result, rsp_flags, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_request_scheduler.sv
// Round-robin arbiter feeding one shared 2-stage registered ALU from two requesters.
// Latency: accept -> rsp_valid after 3 edges; one operation in flight, 4-cycle minimum issue interval.
// Backpressure: RESP holds while rsp_ready=0; requesters see req_ready=0 until the FSM is back in IDLE.
module alu_request_scheduler #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_request_scheduler_if.slave bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);
    typedef enum logic [1:0] {IDLE, FILL, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;
    logic [3:0]       hold_op;
    logic             hold_id;

    logic             gnt;
    logic [1:0]       rdy;
    logic             accept;
    logic             rsp_vld;
    logic             rsp_hs;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        gnt = bus.req_valid[1];
        if (&bus.req_valid) begin
            gnt = ~last_grant;
        end
        rdy = 2'b00;
        if ((state == IDLE) && !reset && (|bus.req_valid)) begin
            rdy = gnt ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(bus.req_valid & rdy);
    assign rsp_hs = rsp_vld & bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        rsp_vld   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = FILL;
                end
            end
            FILL: state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_vld = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands and opcode stay put from accept to the next accept; the datapath
    // does not register the opcode, so it must not move before the result is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            hold_a     <= '0;
            hold_b     <= '0;
            hold_op    <= '0;
            hold_id    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_a     <= gnt ? bus.req_a1  : bus.req_a0;
                hold_b     <= gnt ? bus.req_b1  : bus.req_b0;
                hold_op    <= gnt ? bus.req_op1 : bus.req_op0;
                hold_id    <= gnt;
                last_grant <= gnt;
            end
            if (rsp_hs) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.alu_a      = hold_a;
    assign bus.alu_b      = hold_b;
    assign bus.alu_opcode = hold_op;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_result = bus.alu_result;
    assign bus.rsp_flags  = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
    assign bus.rsp_id     = hold_id;
endmodule

// File: tb/tb_alu_request_scheduler.sv
// Bench for alu_request_scheduler: registered add/sub datapath model, cycle model of
// the scheduler and a scoreboard queue of accepted requests checked at each response.
module tb_alu_request_scheduler;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic             id;
    } req_t;

    bit               clk;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    alu_request_scheduler_if #(.WIDTH(WIDTH)) bus ();

    alu_request_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {N,Z,C,V,result}; C is the carry out of a+b or a+~b+1.
    function automatic logic [35:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        logic [32:0] s;
        logic        v;
        if (op == 4'h1) begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end
        return {s[31], (s[31:0] == 32'd0), s[32], v, s[31:0]};
    endfunction

    // Shared datapath: operands registered, opcode taken live at the output stage.
    logic [31:0] s1_a, s1_b;
    logic [35:0] s2;
    always @(posedge clk) begin
        s1_a <= bus.alu_a;
        s1_b <= bus.alu_b;
        s2   <= alu_eval(s1_a, s1_b, bus.alu_opcode);
    end
    assign bus.alu_result = s2[31:0];
    assign bus.alu_n      = s2[35];
    assign bus.alu_z      = s2[34];
    assign bus.alu_c      = s2[33];
    assign bus.alu_v      = s2[32];

    // Reference model, sampled on the falling edge; inputs only change just after rising edges.
    int          cyc     = 0;
    int          m_state = 0;
    logic        m_last  = 1'b1;
    req_t        m_hold  = '0;
    logic [CNT_W-1:0] m_count = '0;
    req_t        exp_q[$];
    int          acc_q[$];
    logic        id_log[$];

    always @(negedge clk) begin
        logic [1:0]  exp_rdy;
        logic        g;
        logic [35:0] ev;
        req_t        e;
        cyc++;
        g = (&bus.req_valid) ? ~m_last : bus.req_valid[1];
        exp_rdy = 2'b00;
        if (m_state == 0 && !reset && (|bus.req_valid)) exp_rdy = g ? 2'b10 : 2'b01;
        check("req_ready", bus.req_ready, exp_rdy);
        check("busy", busy, m_state != 0);
        check("rsp_valid", bus.rsp_valid, m_state == 3);
        check("alu_a", bus.alu_a, m_hold.a);
        check("alu_b", bus.alu_b, m_hold.b);
        check("alu_opcode", bus.alu_opcode, m_hold.op);
        check("op_count", op_count, m_count);
        if (m_state == 3 && exp_q.size() > 0) begin
            e  = exp_q[0];
            ev = alu_eval(e.a, e.b, e.op);
            check("rsp_result", bus.rsp_result, ev[31:0]);
            check("rsp_flags", bus.rsp_flags, ev[35:32]);
            check("rsp_id", bus.rsp_id, e.id);
        end
        if (reset) begin
            m_state = 0;
            m_last  = 1'b1;
            m_hold  = '0;
            m_count = '0;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (|bus.req_valid) begin
                    e.id = g;
                    e.a  = g ? bus.req_a1  : bus.req_a0;
                    e.b  = g ? bus.req_b1  : bus.req_b0;
                    e.op = g ? bus.req_op1 : bus.req_op0;
                    exp_q.push_back(e);
                    m_hold  = e;
                    m_last  = g;
                    m_state = 1;
                    acc_q.push_back(cyc);
                end
                1: m_state = 2;
                2: m_state = 3;
                default: if (bus.rsp_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        id_log.push_back(e.id);
                    end
                    m_count = m_count + 1'b1;
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (r == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
        end
    endtask

    // Returns just after the rising edge on which requester r was accepted.
    task automatic wait_accept(input int r);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.req_valid[r] && bus.req_ready[r]) hit = 1;
        end
        if (!hit) check("accept_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_accept_any(output int who);
        bit hit = 0;
        who = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) begin
                hit = 1;
                who = bus.req_ready[1] ? 1 : 0;
            end
        end
        if (!hit) check("accept_any_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit hit = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (m_state == 0 && exp_q.size() == 0) hit = 1;
        end
        if (!hit) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        set_req(r, a, b, op);
        bus.req_valid[r] = 1'b1;
        wait_accept(r);
        bus.req_valid[r] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int who;
        int r;
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single op, then tie from a fresh reset
        id_log.delete();
        issue(0, 32'd5, 32'd7, 4'h0);
        check("single_count", op_count, 1);
        check("single_id", id_log.size() == 1 ? id_log[0] : 1'bx, 0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        id_log.delete();
        set_req(0, 32'd10, 32'd10, 4'h1);
        set_req(1, 32'd3, 32'd4, 4'h0);
        bus.req_valid = 2'b11;
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        wait_idle();
        check("tie_n", id_log.size(), 2);
        if (id_log.size() == 2) begin
            check("tie_first", id_log[0], 0);
            check("tie_second", id_log[1], 1);
        end

        // Fairness with both held valid
        id_log.delete();
        acc_q.delete();
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_accept_any(who);
            set_req(who, $urandom, $urandom, 4'($urandom_range(0, 1)));
        end
        bus.req_valid = 2'b00;
        wait_idle();
        check("rr_n", id_log.size(), 6);
        for (int k = 0; k < 6 && k < id_log.size(); k++) check("rr_id", id_log[k], k % 2);
        for (int k = 1; k < acc_q.size(); k++) check("rr_gap", acc_q[k] - acc_q[k-1], 4);

        // Backpressure with requester 0 changing its inputs while stalled
        id_log.delete();
        bus.rsp_ready = 1'b0;
        set_req(0, 32'd100, 32'd58, 4'h1);
        bus.req_valid = 2'b01;
        wait_accept(0);
        set_req(0, 32'd1, 32'd2, 4'h0);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid", bus.rsp_valid, 1);
        check("bp_result", bus.rsp_result, 32'd42);
        check("bp_id", bus.rsp_id, 0);
        check("bp_alu_a", bus.alu_a, 32'd100);
        bus.rsp_ready = 1'b1;
        wait_accept(0);
        bus.req_valid = 2'b00;
        wait_idle();
        check("bp_n", id_log.size(), 2);

        // Reset while the datapath is in EXEC
        set_req(1, 32'd9, 32'd9, 4'h1);
        bus.req_valid = 2'b10;
        wait_accept(1);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mr_busy", busy, 0);
        check("mr_rsp_valid", bus.rsp_valid, 0);
        check("mr_alu_a", bus.alu_a, 0);
        check("mr_alu_b", bus.alu_b, 0);
        check("mr_count", op_count, 0);

        // 17 completions after reset, with occasional response stalls
        for (int k = 0; k < 17; k++) begin
            r = $urandom_range(0, 1);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            set_req(r, $urandom, $urandom, 4'($urandom_range(0, 1)));
            bus.req_valid[r] = 1'b1;
            wait_accept(r);
            bus.req_valid[r] = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            wait_idle();
        end
        check("wrap_count", op_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_request_scheduler.md
# alu_request_scheduler

Round-robin scheduler sharing one registered ALU datapath between two requesters. It owns the operand, opcode and flag path of the shared ALU instance: it grants one request at a time, holds its operands and opcode stable across the datapath's two register stages, and returns the result, flags and requester ID over a valid/ready response channel. The ALU datapath registers its operands and flags but not the opcode. The scheduler therefore holds the opcode constant for the whole operation.

## Interface
- WIDTH, 32, operand/result width; must match the attached ALU datapath
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  WIDTH  requester 0 operands
- req_op0  in  4  requester 0 opcode
- req_a1, req_b1  in  WIDTH  requester 1 operands
- req_op1  in  4  requester 1 opcode
- alu_a, alu_b  out  WIDTH  operands to the datapath input registers
- alu_opcode  out  4  opcode to the datapath (unregistered there)
- alu_result  in  WIDTH  registered datapath result
- alu_n, alu_z, alu_c, alu_v  in  1  registered datapath flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  WIDTH  result of the granted operation
- rsp_flags  out  4  {N,Z,C,V}
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high in any state other than IDLE
- op_count  out  CNT_W  completed responses; wraps modulo 2^CNT_W

## Operation
- The FSM has four states:
  - IDLE: no operation in flight; arbitration is active.
  - FILL: the datapath input registers load the held operands.
  - EXEC: the datapath output registers capture the result.
  - RESP: the response is presented until accepted.
- Arbitration happens in IDLE only. The grant is round-robin on last_grant:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - req_ready[g] = (state==IDLE) & req_valid[g] & ~reset. This is combinational; the other bit is 0.
- Accept means req_valid[g] & req_ready[g] at a clock edge. On accept:
  - The hold registers (a, b, op, id) load from requester g.
  - last_grant <= g.
  - The FSM moves IDLE->FILL.
- Transitions:
  - FILL->EXEC and EXEC->RESP are unconditional.
  - RESP->IDLE on rsp_valid & rsp_ready.
- alu_a, alu_b and alu_opcode are driven from the hold registers at all times. They change only on accept, so the datapath output stays stable through RESP.
- In RESP:
  - rsp_valid=1.
  - rsp_result=alu_result and rsp_flags={alu_n,alu_z,alu_c,alu_v}, passed through.
  - rsp_id=held id.
- In all other states rsp_valid=0. rsp_result, rsp_flags and rsp_id are don't-care outside RESP.
- op_count increments by 1 on each response handshake. It wraps from 2^CNT_W-1 to 0.
- No request is dropped: a requester held valid but not granted keeps req_ready=0 until it is granted.

## Timing
- Accept at edge T:
  - Datapath input registers load at edge T+1.
  - Datapath output registers load at edge T+2.
  - rsp_valid is high in the cycle after edge T+2.
- Minimum issue interval is 4 cycles: accept, FILL, EXEC, RESP with rsp_ready held high. A new accept is possible at the edge after the response handshake.
- Backpressure: RESP lasts while rsp_ready=0. The outputs hold constant during this time.
- Simultaneous events: a requester deasserting valid during FILL, EXEC or RESP has no effect, because the operation was already taken.
- Reset (synchronous, any state including mid-operation):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - Hold registers = 0, so alu_a=0, alu_b=0, alu_opcode=0.
  - op_count=0, rsp_valid=0, busy=0.
  - req_ready=0 while reset is high.
  - Any in-flight operation is discarded with no response.

## Test plan
- The bench attaches a 2-stage registered model that returns a+b for opcode 4'h0 and a-b for opcode 4'h1.
- Single op: req_valid=01, a0=5, b0=7, op0=0 → req_ready=01 for one cycle; rsp_valid 3 cycles after accept with rsp_result=12, rsp_id=0, Z=0; op_count=1.
- Tie: both valid from reset, a0=10, b0=10, op0=1; a1=3, b1=4, op1=0 →
  - requester 0 served first: result 0, Z=1, id 0;
  - requester 1 served next: result 7, id 1;
  - requester 1 sees req_ready=0 throughout the first operation.
- Round-robin fairness: both held valid for 6 operations, rsp_ready tied high → rsp_id sequence 0,1,0,1,0,1; accepts spaced exactly 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, with requester 0's request inputs changed meanwhile → rsp_valid, rsp_result and rsp_id constant; alu_a, alu_b and alu_opcode unchanged; no new accept until the handshake.
- Reset mid-operation: assert reset in EXEC → next cycle state IDLE, rsp_valid=0, busy=0, alu_a=alu_b=0, op_count=0; a subsequent request completes normally.
- Counter wrap: with CNT_W=4, 17 completed operations → op_count reads 1.
